// File: rtl/sequence_detector.sv
// ----------------------------------------------------------------------------
// sequence_detector
// Serial run detector. The flag z is high while the most recent RUN_LEN bits
// sampled on x are all identical (all ones or all zeros). Runs may overlap, so
// z stays high for as long as the run continues. z is a registered Moore
// output with no combinational path from x.
//
// The state is a small run FSM (IDLE / RUN0 / RUN1) plus a saturating run
// counter. Together they cover the RUNb_k states for k = 1..RUN_LEN: the enum
// value gives the polarity of the current run and cnt_r gives k. The counter
// saturates at RUN_LEN and never wraps. Legal RUN_LEN range is 2..16.
// ----------------------------------------------------------------------------
module sequence_detector #(
   parameter int RUN_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic x,
   output logic z
);

   // Counter width is just wide enough to hold the value RUN_LEN itself.
   localparam int CW = $clog2(RUN_LEN + 1);

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX  = CW'(RUN_LEN);

   // IDLE means no bit has been sampled since reset. RUN0 and RUN1 give the
   // polarity of the current run, which is also the most recent sampled bit.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN0 = 2'd1,
      ST_RUN1 = 2'd2
   } state_t;

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic            z_r;

   state_t          next_state_s;
   logic [CW-1:0]   next_cnt_s;
   logic            next_z_s;

   // Derived views of the state, kept for readability and debug visibility.
   logic            valid_s;
   logic            last_s;

   assign valid_s = (state_r != ST_IDLE);
   assign last_s  = (state_r == ST_RUN1);

   // Next-state and next-count logic. An equal bit extends the run and the
   // count saturates at RUN_LEN. A differing bit starts a new run of length 1.
   always_comb begin
      next_state_s = state_r;
      next_cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (x == 1'b1) begin
               next_state_s = ST_RUN1;
            end else begin
               next_state_s = ST_RUN0;
            end
            next_cnt_s = CNT_ONE;
         end
         ST_RUN0: begin
            if (x == 1'b0) begin
               next_state_s = ST_RUN0;
               if (cnt_r >= CNT_MAX) begin
                  next_cnt_s = CNT_MAX;
               end else begin
                  next_cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               next_state_s = ST_RUN1;
               next_cnt_s   = CNT_ONE;
            end
         end
         ST_RUN1: begin
            if (x == 1'b1) begin
               next_state_s = ST_RUN1;
               if (cnt_r >= CNT_MAX) begin
                  next_cnt_s = CNT_MAX;
               end else begin
                  next_cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               next_state_s = ST_RUN0;
               next_cnt_s   = CNT_ONE;
            end
         end
         default: begin
            // An unreachable encoding recovers to IDLE with no history.
            next_state_s = ST_IDLE;
            next_cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // The detect flag is computed from the next state, so the registered z
   // rises on the same edge that samples the RUN_LEN-th equal bit.
   always_comb begin
      if ((next_state_s != ST_IDLE) && (next_cnt_s == CNT_MAX)) begin
         next_z_s = 1'b1;
      end else begin
         next_z_s = 1'b0;
      end
   end

   // State register with asynchronous reset. Reset discards all run history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         z_r     <= 1'b0;
      end else begin
         state_r <= next_state_s;
         cnt_r   <= next_cnt_s;
         z_r     <= next_z_s;
      end
   end

   assign z = z_r;

endmodule

// File: tb/tb_sequence_detector.sv
// ----------------------------------------------------------------------------
// tb_sequence_detector
// Directed bench for sequence_detector with RUN_LEN = 4. Each step drives one
// bit on x and pushes the z value expected after the next rising edge onto a
// scoreboard queue. The entry is popped and compared #1 after that edge.
// ----------------------------------------------------------------------------
module tb_sequence_detector;

   logic clk;
   logic rst;
   logic x;
   logic z;

   int   checks;
   int   errors;
   bit   exp_q[$];

   sequence_detector #(.RUN_LEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .x   (x),
      .z   (z)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so that the run always ends on its own.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // Pops the oldest expected value from the scoreboard and compares it with z.
   task automatic check_pop(input string tag);
      bit exp;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, z=%0b", tag, z);
      end else begin
         exp = exp_q.pop_front();
         checks++;
         assert (z === exp) else begin
            errors++;
            $error("FAIL %s: z=%0b expected %0b", tag, z, exp);
         end
      end
   endtask

   // Drives one bit, queues the expected z, then checks it after the edge.
   task automatic step(input bit xv, input bit exp_z, input string tag);
      x = xv;
      exp_q.push_back(exp_z);
      @(posedge clk);
      #1;
      check_pop(tag);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      x      = 1'b0;

      // Reset held with x toggling: z stays 0 on every edge.
      step(1'b1, 1'b0, "rst_hold0");
      step(1'b0, 1'b0, "rst_hold1");
      step(1'b1, 1'b0, "rst_hold2");
      step(1'b1, 1'b0, "rst_hold3");
      step(1'b1, 1'b0, "rst_hold4");
      step(1'b1, 1'b0, "rst_hold5");
      rst = 1'b0;

      // Ones run: a 0, then four 1s. z rises after the 4th 1 and falls on the break.
      step(1'b0, 1'b0, "ones_pre0");
      step(1'b1, 1'b0, "ones_1");
      step(1'b1, 1'b0, "ones_2");
      step(1'b1, 1'b0, "ones_3");
      step(1'b1, 1'b1, "ones_4");
      step(1'b0, 1'b0, "ones_break");

      // Zeros run after a 1. Extra zeros keep z high, then a 1 drops it.
      step(1'b1, 1'b0, "zeros_pre1");
      step(1'b0, 1'b0, "zeros_1");
      step(1'b0, 1'b0, "zeros_2");
      step(1'b0, 1'b0, "zeros_3");
      step(1'b0, 1'b1, "zeros_4");
      step(1'b0, 1'b1, "zeros_5");
      step(1'b0, 1'b1, "zeros_6");
      step(1'b1, 1'b0, "zeros_break");

      // Alternating noise never reaches a run of 4.
      step(1'b1, 1'b0, "alt_0");
      step(1'b0, 1'b0, "alt_1");
      step(1'b1, 1'b0, "alt_2");
      step(1'b0, 1'b0, "alt_3");
      step(1'b1, 1'b0, "alt_4");
      step(1'b0, 1'b0, "alt_5");

      // Near miss: the longest run is 3, so z stays 0.
      step(1'b1, 1'b0, "near_0");
      step(1'b1, 1'b0, "near_1");
      step(1'b1, 1'b0, "near_2");
      step(1'b0, 1'b0, "near_3");
      step(1'b0, 1'b0, "near_4");
      step(1'b0, 1'b0, "near_5");
      step(1'b1, 1'b0, "near_6");

      // Long run of 1s. This starts a new run after the preceding 1, so that
      // 1 counts as the first. z stays high and the count must not wrap.
      step(1'b1, 1'b0, "long_2");
      step(1'b1, 1'b0, "long_3");
      for (int i = 4; i <= 14; i++) begin
         step(1'b1, 1'b1, $sformatf("long_%0d", i));
      end

      // Polarity switch: four 0s give z = 0,0,0,1.
      step(1'b0, 1'b0, "pol_0a");
      step(1'b0, 1'b0, "pol_0b");
      step(1'b0, 1'b0, "pol_0c");
      step(1'b0, 1'b1, "pol_0d");

      // Asynchronous reset while z is high. z drops with no clock edge.
      #2;
      rst = 1'b1;
      exp_q.push_back(1'b0);
      #1;
      check_pop("async_rst");
      #1;
      rst = 1'b0;

      // After the reset the history is gone, so four 1s are needed.
      step(1'b1, 1'b0, "post_rst_1");
      step(1'b1, 1'b0, "post_rst_2");
      step(1'b1, 1'b0, "post_rst_3");
      step(1'b1, 1'b1, "post_rst_4");

      // Mid-run reset: three 1s, a reset pulse between edges, then another 1.
      step(1'b0, 1'b0, "mid_pre0");
      step(1'b1, 1'b0, "mid_1");
      step(1'b1, 1'b0, "mid_2");
      step(1'b1, 1'b0, "mid_3");
      #2;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step(1'b1, 1'b0, "mid_after_1");
      step(1'b1, 1'b0, "mid_after_2");
      step(1'b1, 1'b0, "mid_after_3");
      step(1'b1, 1'b1, "mid_after_4");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
